// File: rtl/multi_shift_pkg.sv
// ---------------------------------------------------------------------------
// multi_shift_pkg
// Shared constants for the multi-step shifter and its one-step datapath:
//   - HSEL shift-mode encodings
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - CNT_MAX, the saturation limit for the requested step count
//   - small helpers for count saturation and carry-mode detection
// ---------------------------------------------------------------------------
package multi_shift_pkg;

    localparam logic [2:0] HSEL_PASS = 3'b000;
    localparam logic [2:0] HSEL_SHL  = 3'b001;
    localparam logic [2:0] HSEL_SHR  = 3'b010;
    localparam logic [2:0] HSEL_ZERO = 3'b011;
    localparam logic [2:0] HSEL_RLC  = 3'b100;
    localparam logic [2:0] HSEL_ROL  = 3'b101;
    localparam logic [2:0] HSEL_ROR  = 3'b110;
    localparam logic [2:0] HSEL_RRC  = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] CNT_MAX = 4'd8;

    // Requests for more than eight steps are clamped: a 9-bit rotate
    // through carry already covers every useful distance.
    function automatic logic [3:0] sat_count(input logic [3:0] cnt);
        return (cnt > CNT_MAX) ? CNT_MAX : cnt;
    endfunction

    // The two rotate-through-carry modes are the only ones that touch
    // the carry register and report a carry-out.
    function automatic logic uses_carry(input logic [2:0] mode);
        return (mode == HSEL_RLC) || (mode == HSEL_RRC);
    endfunction

endpackage

// File: rtl/SHIFTER.sv
// ---------------------------------------------------------------------------
// SHIFTER
// Combinational one-step shifter.
//   F    in  8  operand
//   HSEL in  3  shift mode (see multi_shift_pkg HSEL_* constants)
//   CI   in  1  carry-in, used as the shift-in bit in the through-carry modes
//   S    out 8  result of one step
//   CO   out 1  bit shifted out in the through-carry modes, 0 otherwise
// ---------------------------------------------------------------------------
module SHIFTER
    import multi_shift_pkg::*;
(
    input  logic [7:0] F,
    input  logic [2:0] HSEL,
    input  logic       CI,
    output logic [7:0] S,
    output logic       CO
);

    always_comb begin
        S  = F;
        CO = 1'b0;
        case (HSEL)
            HSEL_PASS: S = F;
            HSEL_SHL:  S = {F[6:0], 1'b0};
            HSEL_SHR:  S = {1'b0, F[7:1]};
            HSEL_ZERO: S = 8'h00;
            // {CO,S} is {CI,F} rotated left by one across nine bits
            HSEL_RLC: begin
                S  = {F[6:0], CI};
                CO = F[7];
            end
            HSEL_ROL:  S = {F[6:0], F[7]};
            HSEL_ROR:  S = {F[0], F[7:1]};
            // {CO,S} is {CI,F} rotated right by one across nine bits
            HSEL_RRC: begin
                S  = {CI, F[7:1]};
                CO = F[0];
            end
            default: begin
                S  = F;
                CO = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multi_shift.sv
// ---------------------------------------------------------------------------
// multi_shift
// Applies the one-step SHIFTER CNT times (saturated to 8) to an operand,
// one step per clock, under a small IDLE/SHIFT/DONE FSM.
//   CLK   in  1  clock, rising-edge
//   RST   in  1  synchronous active-high reset
//   START in  1  request; accepted when READY is high
//   F     in  8  operand          (sampled on accept)
//   HSEL  in  3  shift mode       (sampled on accept)
//   CNT   in  4  step count       (sampled on accept, 9..15 -> 8)
//   CI    in  1  initial carry    (sampled on accept)
//   READY out 1  high in IDLE and DONE
//   DONE  out 1  high for the cycle a result becomes available
//   S     out 8  registered result, held until the next result
//   CO    out 1  registered carry-out, held with S
// ---------------------------------------------------------------------------
module multi_shift
    import multi_shift_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] F,
    input  logic [2:0] HSEL,
    input  logic [3:0] CNT,
    input  logic       CI,
    output logic       READY,
    output logic       DONE,
    output logic [7:0] S,
    output logic       CO
);

    logic [1:0] state_q, state_d;
    logic [7:0] work_q,  work_d;
    logic       carry_q, carry_d;
    logic [2:0] mode_q,  mode_d;
    logic [3:0] count_q, count_d;
    logic [7:0] s_q,     s_d;
    logic       co_q,    co_d;

    logic [7:0] step_s;
    logic       step_co;
    logic       accept;
    logic [3:0] start_count;

    SHIFTER u_step (
        .F    (work_q),
        .HSEL (mode_q),
        .CI   (carry_q),
        .S    (step_s),
        .CO   (step_co)
    );

    assign READY       = (state_q != ST_SHIFT);
    assign DONE        = (state_q == ST_DONE);
    assign S           = s_q;
    assign CO          = co_q;
    assign accept      = START && READY;
    assign start_count = sat_count(CNT);

    // Next-state logic. In SHIFT the work/carry registers advance by one
    // step; the result registers only change on the edge that enters DONE,
    // so S/CO stay stable while a later request is still shifting.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        count_d = count_q;
        s_d     = s_q;
        co_d    = co_q;

        case (state_q)
            ST_SHIFT: begin
                work_d  = step_s;
                count_d = count_q - 4'd1;
                if (uses_carry(mode_q)) begin
                    carry_d = step_co;
                end
                if (count_q == 4'd1) begin
                    state_d = ST_DONE;
                    s_d     = step_s;
                    co_d    = uses_carry(mode_q) ? step_co : 1'b0;
                end
            end

            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    work_d  = F;
                    carry_d = CI;
                    mode_d  = HSEL;
                    count_d = start_count;
                    // A zero-step request completes straight away with
                    // the operand and initial carry as the result.
                    if (start_count == 4'd0) begin
                        state_d = ST_DONE;
                        s_d     = F;
                        co_d    = uses_carry(HSEL) ? CI : 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset wins over START and
    // abandons any operation in progress without a DONE pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            work_q  <= 8'h00;
            carry_q <= 1'b0;
            mode_q  <= HSEL_PASS;
            count_q <= 4'd0;
            s_q     <= 8'h00;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

endmodule

// File: tb/tb_multi_shift.sv
// ---------------------------------------------------------------------------
// tb_multi_shift
// Self-checking bench for multi_shift. Results are predicted by a reference
// model that treats each mode as a single multi-bit shift/rotate of the
// operand (or of the 9-bit {carry,operand} word for the through-carry modes).
// ---------------------------------------------------------------------------
module tb_multi_shift;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [7:0] F;
    logic [2:0] HSEL;
    logic [3:0] CNT;
    logic       CI;
    logic       READY;
    logic       DONE;
    logic [7:0] S;
    logic       CO;

    int vectors;
    int miscompares;

    multi_shift dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .F     (F),
        .HSEL  (HSEL),
        .CNT   (CNT),
        .CI    (CI),
        .READY (READY),
        .DONE  (DONE),
        .S     (S),
        .CO    (CO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: the whole operation as one shift/rotate by n positions.
    function automatic void ref_shift(input logic [7:0] f, input logic [2:0] h,
                                      input logic [3:0] c, input logic ci,
                                      output logic [7:0] s, output logic co);
        int          n;
        logic [15:0] d;
        logic [8:0]  w;
        logic [17:0] dd;
        n  = (c > 4'd8) ? 8 : int'(c);
        w  = {ci, f};
        s  = f;
        co = 1'b0;
        case (h)
            3'b000: s = f;
            3'b001: s = f << n;
            3'b010: s = f >> n;
            3'b011: s = (n == 0) ? f : 8'h00;
            3'b101: begin d = {f, f} << n; s = d[15:8]; end
            3'b110: begin d = {f, f} >> n; s = d[7:0]; end
            3'b100: begin dd = {w, w} << n; s = dd[16:9]; co = dd[17]; end
            3'b111: begin dd = {w, w} >> n; s = dd[7:0]; co = dd[8]; end
            default: s = f;
        endcase
    endfunction

    // Issues one request and waits (bounded) for DONE; returns the number of
    // edges after the accepting edge at which DONE was seen (-1 on timeout).
    // Inputs are scrambled while the operation runs.
    task automatic run_op(input logic [7:0] f, input logic [2:0] h,
                          input logic [3:0] c, input logic ci,
                          output int lat, output logic [7:0] s, output logic co);
        @(negedge CLK);
        START = 1'b1; F = f; HSEL = h; CNT = c; CI = ci;
        @(posedge CLK); #1;
        START = 1'b0;
        lat   = -1;
        for (int k = 0; k < 20; k++) begin
            if (DONE) begin
                lat = k;
                break;
            end
            F    = 8'($urandom);
            HSEL = 3'($urandom);
            CNT  = 4'($urandom);
            CI   = 1'($urandom);
            @(posedge CLK); #1;
        end
        s  = S;
        co = CO;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1; START = 1'b1; F = 8'hFF; HSEL = 3'b001; CNT = 4'd2; CI = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        vectors++;
        if (READY !== 1'b1 || DONE !== 1'b0 || S !== 8'h00 || CO !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset: READY=%b DONE=%b S=%h CO=%b, want READY=1 DONE=0 S=00 CO=0",
                     READY, DONE, S, CO);
        end
        @(negedge CLK);
        RST = 1'b0; START = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_directed();
        logic [7:0] f_t [4] = '{8'h81, 8'h80, 8'h01, 8'hA5};
        logic [2:0] h_t [4] = '{3'b101, 3'b100, 3'b111, 3'b011};
        logic [3:0] c_t [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
        logic       i_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] s_t [4] = '{8'h0C, 8'h03, 8'h00, 8'hA5};
        logic       o_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int         lat;
        logic [7:0] s;
        logic       co;
        for (int i = 0; i < 4; i++) begin
            run_op(f_t[i], h_t[i], c_t[i], i_t[i], lat, s, co);
            vectors++;
            if (lat !== int'(c_t[i]) || s !== s_t[i] || co !== o_t[i]) begin
                miscompares++;
                $display("[TB] FAIL directed%0d: lat=%0d S=%h CO=%b, want lat=%0d S=%h CO=%b",
                         i, lat, s, co, c_t[i], s_t[i], o_t[i]);
            end
            idle_cycles(2);
        end
    endtask

    task automatic test_saturate();
        int done_cnt;
        int first_lat;
        int ready_bad;
        @(negedge CLK);
        START = 1'b1; F = 8'hFF; HSEL = 3'b001; CNT = 4'd15; CI = 1'b0;
        @(posedge CLK); #1;
        START     = 1'b0;
        done_cnt  = 0;
        first_lat = -1;
        ready_bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (DONE) begin
                done_cnt++;
                if (first_lat < 0) first_lat = k;
            end
            if (k < 8 && READY !== 1'b0) ready_bad++;
            if (first_lat == 8 && k == 8) begin
                vectors++;
                if (S !== 8'h00 || CO !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL saturate_result: S=%h CO=%b, want S=00 CO=0", S, CO);
                end
            end
            START = (k == 2);
            if (k == 2) begin
                F = 8'h55; HSEL = 3'b101; CNT = 4'd0; CI = 1'b1;
            end
            @(posedge CLK); #1;
        end
        START = 1'b0;
        vectors++;
        if (done_cnt !== 1 || first_lat !== 8 || ready_bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL saturate: dones=%0d lat=%0d readyerr=%0d, want dones=1 lat=8 readyerr=0",
                     done_cnt, first_lat, ready_bad);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        int         lat;
        logic [7:0] s;
        logic       co;
        int         done_cnt;
        // leave a nonzero result behind so the reset clearing S is visible
        run_op(8'h80, 3'b100, 4'd1, 1'b1, lat, s, co);
        idle_cycles(2);
        @(negedge CLK);
        START = 1'b1; F = 8'h81; HSEL = 3'b101; CNT = 4'd7; CI = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        vectors++;
        if (S !== 8'h00 || CO !== 1'b0 || READY !== 1'b1 || DONE !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: S=%h CO=%b READY=%b DONE=%b, want S=00 CO=0 READY=1 DONE=0",
                     S, CO, READY, DONE);
        end
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK); #1;
            if (DONE) done_cnt++;
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_nodone: dones=%0d, want 0", done_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] f, s, es;
        logic [2:0] h;
        logic [3:0] c;
        logic       ci, co, eco;
        int         lat;
        for (int i = 0; i < 60; i++) begin
            f  = 8'($urandom);
            h  = 3'($urandom);
            c  = 4'($urandom_range(15, 0));
            ci = 1'($urandom);
            ref_shift(f, h, c, ci, es, eco);
            run_op(f, h, c, ci, lat, s, co);
            vectors++;
            if (lat !== ((c > 4'd8) ? 8 : int'(c)) || s !== es || co !== eco) begin
                miscompares++;
                $display("[TB] FAIL random%0d f=%h h=%0d c=%0d ci=%b: lat=%0d S=%h CO=%b, want S=%h CO=%b",
                         i, f, h, c, ci, lat, s, co, es, eco);
            end
            idle_cycles(2);
            vectors++;
            if (S !== es || CO !== eco || DONE !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL hold%0d: S=%h CO=%b DONE=%b, want S=%h CO=%b DONE=0",
                         i, S, CO, DONE, es, eco);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f, s, es;
        logic [2:0] h;
        logic [3:0] c;
        logic       ci, co, eco;
        int         lat;
        // each request is issued in the DONE cycle of the previous one
        for (int i = 0; i < 12; i++) begin
            f  = 8'($urandom);
            h  = 3'($urandom);
            c  = (i % 3 == 0) ? 4'd0 : 4'($urandom_range(9, 1));
            ci = 1'($urandom);
            ref_shift(f, h, c, ci, es, eco);
            run_op(f, h, c, ci, lat, s, co);
            vectors++;
            if (lat !== ((c > 4'd8) ? 8 : int'(c)) || s !== es || co !== eco) begin
                miscompares++;
                $display("[TB] FAIL b2b%0d f=%h h=%0d c=%0d ci=%b: lat=%0d S=%h CO=%b, want S=%h CO=%b",
                         i, f, h, c, ci, lat, s, co, es, eco);
            end
        end
        idle_cycles(2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST   = 1'b1;
        START = 1'b0;
        F     = 8'h00;
        HSEL  = 3'b000;
        CNT   = 4'd0;
        CI    = 1'b0;
        test_reset();
        test_directed();
        test_saturate();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_shift.md
MULTI_SHIFT -- requirements
Module: multi_shift

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: CLK for the clock and RST for the reset.
REQ-002 Port: CLK  in  1  system clock; all state updates on its rising edge.
REQ-003 Port: RST  in  1  synchronous active-high reset.
REQ-004 Port: START  in  1  request to start a multi-step shift; accepted only when START=1 and READY=1.
REQ-005 Port: F  in  8  operand, sampled on the accepting edge.
REQ-006 Port: HSEL  in  3  shift mode, sampled on the accepting edge; same encoding as the one-step shifter (000 pass, 001 shl, 010 shr, 011 zero, 100 rotl-through-carry, 101 rotl, 110 rotr, 111 rotr-through-carry).
REQ-007 Port: CNT  in  4  number of single-step shifts, sampled on the accepting edge; values 9..15 SHALL saturate to 8.
REQ-008 Port: CI  in  1  initial carry, sampled on the accepting edge.
REQ-009 Port: READY  out  1  high when a request can be accepted.
REQ-010 Port: DONE  out  1  single-cycle completion pulse.
REQ-011 Port: S  out  8  registered result, held from the DONE cycle until the next accepted request completes.
REQ-012 Port: CO  out  1  registered carry-out, held with S.

Function
REQ-013 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-014 READY SHALL be 1 in IDLE and DONE and 0 in SHIFT.
REQ-015 On accept, the block SHALL load the work register with F, the carry register with CI, latch HSEL, and set the remaining count to the saturated CNT.
REQ-016 On accept with a count of 0, the next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-017 Each SHIFT cycle SHALL apply exactly one step of the latched mode to the work register and decrement the remaining count.
REQ-018 In modes 100 and 111, each SHIFT step SHALL use the carry register as the shift-in bit and SHALL load the carry register with the bit that falls out, forming a 9-bit rotate.
REQ-019 In all other modes the carry register SHALL be left unchanged and CO SHALL be reported as 0.
REQ-020 SHIFT SHALL transition to DONE on the step that brings the remaining count to 0.
REQ-021 On entering DONE, S SHALL be loaded with the work-register value that includes the final step.
REQ-022 On entering DONE, CO SHALL be loaded with the carry register in modes 100/111 and with 0 otherwise.
REQ-023 Count 0 SHALL yield S=F for every mode; it SHALL yield CO=CI in modes 100/111 and CO=0 otherwise.
REQ-024 Latency: DONE SHALL be high in the cycle after the CNT-th rising edge following the accepting edge; for CNT=0 this is the cycle immediately after the accepting edge.
REQ-025 DONE SHALL go to IDLE on the next edge, or to SHIFT/DONE if a new request is accepted in the DONE cycle (back-to-back).
REQ-026 START while READY=0 SHALL be ignored and SHALL not be queued.
REQ-027 F, HSEL, CNT and CI changing during SHIFT SHALL have no effect on the operation in progress.

Reset
REQ-028 RST=1 at a rising edge SHALL force state IDLE, S=0x00, CO=0 and DONE=0, giving READY=1, and SHALL clear the work, carry and count registers.
REQ-029 RST SHALL take priority over START; an operation interrupted by reset SHALL produce no DONE pulse.

Structure
REQ-030 A shared package SHALL hold the HSEL mode constants, the state encoding (IDLE/SHIFT/DONE) and CNT_MAX=8.
REQ-031 The single-step datapath SHALL be one instance of the existing one-step shifter module SHIFTER, driven by the work register, the latched HSEL and the carry register; no other sub-modules SHALL be used.

Verification
REQ-032 F=0x81, HSEL=101, CNT=3 -> DONE 3 cycles after accept, S=0x0C, CO=0.
REQ-033 F=0x80, HSEL=100, CI=1, CNT=2 -> S=0x03, CO=0.
REQ-034 F=0x01, HSEL=111, CI=0, CNT=1 -> S=0x00, CO=1.
REQ-035 F=0xA5, HSEL=011, CNT=0 -> DONE in the cycle after accept, S=0xA5, CO=0.
REQ-036 F=0xFF, HSEL=001, CNT=15 with START pulsed again mid-SHIFT -> saturates to 8 steps, S=0x00, exactly one DONE, second START ignored.
REQ-037 Start CNT=7, assert RST on the 3rd SHIFT edge -> next cycle S=0x00, CO=0, READY=1, and no DONE pulse follows.
